// File: rtl/instr_decode_ctrl_pkg.sv
// Shared definitions for the instruction decoder/sequencer.
// Holds the FSM state encoding, opcode and extension constants, flag bit
// indices and SKIP condition codes.
package instr_decode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  // Major opcodes (Instr[15:12])
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_ADDCI = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_SKIP  = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;

  // Register-class extension codes
  localparam logic [3:0] EXT_NOP  = 4'b0000;
  localparam logic [3:0] EXT_CMP  = 4'b1011;

  // Flag bus bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_N = 4;

  // SKIP condition codes (Rdest field of a SKIP word)
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_FS = 4'b0100;
  localparam logic [3:0] CC_FC = 4'b0101;
  localparam logic [3:0] CC_MI = 4'b0110;
  localparam logic [3:0] CC_PL = 4'b0111;
  localparam logic [3:0] CC_AL = 4'b1110;

endpackage

// File: rtl/instr_decode_ctrl_decode.sv
// Combinational field decoder (imm_field_decode).
// Maps an instruction word to raw control values; the top gates them with
// the FSM state.
//   ir         in   instruction register
//   opcode     out  ALU opcode
//   rsrc_sel   out  source register select
//   rdest_sel  out  destination register select
//   imm_sel    out  immediate operand select
//   imm_val    out  extended immediate
//   wr_en      out  one-hot register write enable
//   is_skip    out  word is a SKIP
//   is_illegal out  word has an illegal major opcode
module imm_field_decode
  import instr_decode_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic [7:0]  opcode,
  output logic [3:0]  rsrc_sel,
  output logic [3:0]  rdest_sel,
  output logic        imm_sel,
  output logic [15:0] imm_val,
  output logic [15:0] wr_en,
  output logic        is_skip,
  output logic        is_illegal
);

  logic [3:0] op, rd, ext, rs;
  logic [7:0] imm8;
  logic       is_cmp;
  logic       writes;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ext  = ir[7:4];
  assign rs   = ir[3:0];
  assign imm8 = ir[7:0];

  assign is_cmp = ((op == OP_REG) && (ext == EXT_CMP)) || (op == OP_CMPI);

  always_comb begin
    opcode     = 8'h00;
    rsrc_sel   = 4'h0;
    rdest_sel  = 4'h0;
    imm_sel    = 1'b0;
    imm_val    = 16'h0000;
    writes     = 1'b0;
    is_skip    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_REG: begin
        opcode    = {op, ext};
        rsrc_sel  = rs;
        rdest_sel = rd;
        writes    = (ext != EXT_NOP);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_ADDCI: begin
        opcode    = {op, 4'h0};
        rsrc_sel  = rd;
        rdest_sel = rd;
        imm_sel   = 1'b1;
        imm_val   = {8'h00, imm8};
        writes    = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        opcode    = {op, 4'h0};
        rsrc_sel  = rd;
        rdest_sel = rd;
        imm_sel   = 1'b1;
        imm_val   = {{8{imm8[7]}}, imm8};
        writes    = 1'b1;
      end
      OP_SHIFT: begin
        // Rsrc field is the shift amount, carried on the immediate bus
        // while the operand register comes from the register path.
        opcode    = {op, ext};
        rsrc_sel  = rd;
        rdest_sel = rd;
        imm_val   = {12'h000, rs};
        writes    = 1'b1;
      end
      OP_SKIP: is_skip = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  assign wr_en = (writes && !is_cmp) ? (16'h0001 << rd) : 16'h0000;

endmodule

// File: rtl/instr_decode_ctrl.sv
// Instruction decoder and sequencer driving the data_path control bus.
// Accepts 16-bit words over valid/ready, executes each for one cycle,
// supports a flag-conditioned SKIP and traps on illegal encodings.
//   Clk, Rst          clock, async active-low reset
//   Instr/_valid/_ready  instruction handshake
//   Flags             live datapath flags (C,Z,F,L,N)
//   Rsrc_mux_sel, Rdest_mux_sel, Imm_mux_sel, Imm_val, Opcode, Reg_File_En
//                     control bus, NOP values outside EXEC
//   Trap              sticky illegal-instruction indicator
//   Retired           count of executed, non-skipped legal instructions
//
// state | meaning
// IDLE  | ready for a word; latch into IR on valid
// EXEC  | drive decoded controls for one cycle
// TRAP  | illegal word seen; absorbing, never ready
module instr_decode_ctrl
  import instr_decode_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [BIT_WIDTH-1:0]    Instr,
  input  logic                    Instr_valid,
  output logic                    Instr_ready,
  input  logic [FLAG_WIDTH-1:0]   Flags,
  output logic [SEL_WIDTH-1:0]    Rsrc_mux_sel,
  output logic [SEL_WIDTH-1:0]    Rdest_mux_sel,
  output logic                    Imm_mux_sel,
  output logic [BIT_WIDTH-1:0]    Imm_val,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [BIT_WIDTH-1:0]    Reg_File_En,
  output logic                    Trap,
  output logic [BIT_WIDTH-1:0]    Retired
);

  state_t         state_q, state_d;
  logic [15:0]    ir_q;
  logic           skip_pending_q;
  logic           trap_q;
  logic [15:0]    retired_q;

  logic [7:0]     dec_opcode;
  logic [3:0]     dec_rsrc, dec_rdest;
  logic           dec_imm_sel;
  logic [15:0]    dec_imm_val, dec_wr_en;
  logic           dec_skip, dec_illegal;
  logic           exec_live;
  logic           cond_true;
  logic           unused_flag_l;

  imm_field_decode u_decode (
    .ir         (ir_q),
    .opcode     (dec_opcode),
    .rsrc_sel   (dec_rsrc),
    .rdest_sel  (dec_rdest),
    .imm_sel    (dec_imm_sel),
    .imm_val    (dec_imm_val),
    .wr_en      (dec_wr_en),
    .is_skip    (dec_skip),
    .is_illegal (dec_illegal)
  );

  // A word executing under skip_pending is never decoded.
  assign exec_live     = (state_q == ST_EXEC) && !skip_pending_q;
  assign unused_flag_l = Flags[FLAG_L];

  always_comb begin
    cond_true = 1'b0;
    case (ir_q[11:8])
      CC_EQ:   cond_true =  Flags[FLAG_Z];
      CC_NE:   cond_true = !Flags[FLAG_Z];
      CC_CS:   cond_true =  Flags[FLAG_C];
      CC_CC:   cond_true = !Flags[FLAG_C];
      CC_FS:   cond_true =  Flags[FLAG_F];
      CC_FC:   cond_true = !Flags[FLAG_F];
      CC_MI:   cond_true =  Flags[FLAG_N];
      CC_PL:   cond_true = !Flags[FLAG_N];
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Instr_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = (exec_live && dec_illegal) ? ST_TRAP : ST_IDLE;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= ST_IDLE;
      ir_q           <= 16'h0000;
      skip_pending_q <= 1'b0;
      trap_q         <= 1'b0;
      retired_q      <= 16'h0000;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && Instr_valid) ir_q <= Instr;
      if (state_q == ST_EXEC) begin
        if (skip_pending_q) begin
          skip_pending_q <= 1'b0;
        end else if (dec_illegal) begin
          trap_q <= 1'b1;
        end else begin
          retired_q <= retired_q + 16'h0001;
          if (dec_skip && cond_true) skip_pending_q <= 1'b1;
        end
      end
    end
  end

  // Rst term keeps ready low while reset is held even though state is IDLE.
  assign Instr_ready = Rst && (state_q == ST_IDLE);

  always_comb begin
    Rsrc_mux_sel  = '0;
    Rdest_mux_sel = '0;
    Imm_mux_sel   = 1'b0;
    Imm_val       = '0;
    Opcode        = '0;
    Reg_File_En   = '0;
    if (exec_live) begin
      Rsrc_mux_sel  = dec_rsrc;
      Rdest_mux_sel = dec_rdest;
      Imm_mux_sel   = dec_imm_sel;
      Imm_val       = dec_imm_val;
      Opcode        = dec_opcode;
      Reg_File_En   = dec_wr_en;
    end
  end

  assign Trap    = trap_q;
  assign Retired = retired_q;

endmodule
